note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Command scheduler for the synth voice (squaregen + envelope_generator) on clk_calc.
//  Pops 32-bit note commands from the CPU write FIFO (read latency 1, standard mode).
//  Drives the tone period and one-cycle note_on/note_off events, holding each note
//  for a programmed number of ticks. Replaces direct FIFO-data-to-period wiring.
// PARAMETERS
//  TICK_DIV  48000  clocks per duration tick; legal range 2..2**TICK_W
//  TICK_W    16     width of the tick prescaler counter
// PORTS
//  clk          in   1   clock (clk_calc domain)
//  rst_b        in   1   asynchronous reset, active low
//  en           in   1   playback enable
//  flush        in   1   synchronous abort; priority over everything except reset
//  cmd_data     in   32  FIFO dout; valid the cycle after the cycle cmd_rd_en is high
//  cmd_empty    in   1   FIFO empty
//  cmd_rd_en    out  1   FIFO pop strobe, registered, one cycle per command
//  period       out  23  squaregen period, registered
//  note_on      out  1   one-cycle envelope trigger
//  note_off     out  1   one-cycle envelope release
//  busy         out  1   high when state != IDLE
//  underrun     out  1   one-cycle pulse: note ended with en=1 and FIFO empty
// BEHAVIOUR
//  Command word:
//   [31]     STOP
//   [30:23]  dur, in ticks; 0 means 256
//   [22:0]   period; 0 means rest
//  Reset: state IDLE; halted=0; all outputs 0; tick/dur counters 0.
//  States: IDLE, READ, DECODE, PLAY.
//  IDLE -> READ when en & !cmd_empty & !halted. cmd_rd_en<=1 on that edge, for one cycle.
//  READ -> DECODE unconditionally. cmd_rd_en<=0.
//  DECODE: samples cmd_data.
//   STOP=1: halted<=1; go to IDLE; period and note outputs unchanged.
//   else: period<=cmd[22:0]; dur_cnt<=dur (0->256); tick_cnt<=0; go to PLAY.
//     note_on<=1 for one cycle iff cmd[22:0]!=0.
//   note_on is therefore high 2 cycles after cmd_rd_en.
//  PLAY:
//   tick_cnt counts 0..TICK_DIV-1 and wraps; dur_cnt decrements on each wrap.
//   The note lasts exactly dur*TICK_DIV cycles, measured from the DECODE edge.
//  End-of-note edge (last tick wrap with dur_cnt=1):
//   - note_off<=1 iff period!=0; period is held so the envelope release sounds.
//   - en & !cmd_empty: go to READ with cmd_rd_en<=1 on the same edge (back-to-back).
//   - en & cmd_empty: underrun<=1; go to IDLE.
//   - !en: go to IDLE. Deasserting en never truncates the current note.
//  halted: cleared on any cycle with en=0. While set, IDLE never reads.
//  flush=1, any state:
//   - note_off<=1 iff state=PLAY & period!=0.
//   - period<=0; cmd_rd_en<=0; halted<=0; go to IDLE.
//   - No read while flush is high.
//   - flush in READ: the popped word is discarded.
//  Simultaneous events:
//   - note_off and cmd_rd_en may share a cycle.
//   - note_on and note_off never share a cycle.
//  Async reset mid-note: outputs to 0 immediately. A pending FIFO word is not re-read.
// CONFIGURATION
//  NOTE_SEQ_UNDERRUN_CNT_EN defined:
//   - adds output underrun_cnt[15:0].
//   - Increments with each underrun pulse and saturates at 16'hFFFF.
//   - Cleared by reset and by flush.
//  Not defined: port absent; underrun pulse only.
// TESTING (TICK_DIV=4)
//  1. rst_b low, FIFO non-empty, en=1 -> all outputs 0, no cmd_rd_en until release.
//  2. Word 0x01001000 (dur 2, period 0x1000), en=1:
//     cmd_rd_en 1 cycle -> 2 cycles later period=0x001000 and note_on.
//     -> note_off 8 cycles after note_on, same cycle as underrun; busy then falls.
//  3. Words 0x00800100 then 0x00800200 queued:
//     cmd_rd_en in the same cycle as the first note_off.
//     -> second note_on 2 cycles later with period=0x000200.
//  4. Rest 0x00800000 -> period=0, no note_on/note_off, busy high for 2+4 cycles after the pop.
//  5. Queue 0x80000000 then a note -> IDLE after STOP, no pop while en=1.
//     -> drop en for 1 cycle, re-raise -> note popped.
//  6. Word 0x00000040 (dur 0 = 1024 cycles), flush after 100 cycles:
//     -> note_off next cycle, period=0, IDLE, no pop while flush is high.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: schedules 32-bit note commands from the CPU write FIFO
// onto the synth voice. It drives the squaregen period and one-cycle
// note_on/note_off envelope events, and holds each note for a programmed
// number of duration ticks.
// Command word: [31] STOP, [30:23] duration in ticks (0 = 256),
// [22:0] period (0 = rest).
// Optional feature: define NOTE_SEQ_UNDERRUN_CNT_EN to add the saturating
// underrun_cnt[15:0] output.
module note_sequencer #(
  parameter int TICK_DIV = 48000,
  parameter int TICK_W   = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] cmd_data,
  input  logic        cmd_empty,
  output logic        cmd_rd_en,
  output logic [22:0] period,
  output logic        note_on,
  output logic        note_off,
  output logic        busy,
  output logic        underrun
`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DECODE, S_PLAY} state_e;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic              halted_q, halted_d;
  logic              rd_q, rd_d;
  logic [22:0]       period_q, period_d;
  logic              on_q, on_d;
  logic              off_q, off_d;
  logic              und_q, und_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [8:0]        dur_q, dur_d;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      rd_q     <= 1'b0;
      period_q <= '0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
      und_q    <= 1'b0;
      tick_q   <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      period_q <= period_d;
      on_q     <= on_d;
      off_q    <= off_d;
      und_q    <= und_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
    end
  end

  // Next-state logic: flush overrides everything; pulses default low
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    rd_d     = 1'b0;
    period_d = period_q;
    on_d     = 1'b0;
    off_d    = 1'b0;
    und_d    = 1'b0;
    tick_d   = tick_q;
    dur_d    = dur_q;
    if (flush) begin
      off_d    = (state_q == S_PLAY) && (period_q != '0);
      period_d = '0;
      halted_d = 1'b0;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en && !cmd_empty && !halted_q) begin
            rd_d    = 1'b1;
            state_d = S_READ;
          end
        end
        S_READ: state_d = S_DECODE;
        S_DECODE: begin
          if (cmd_data[31]) begin
            // STOP: park in IDLE until en is dropped; the sounding period stays.
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            period_d = cmd_data[22:0];
            dur_d    = (cmd_data[30:23] == 8'd0) ? 9'd256 : {1'b0, cmd_data[30:23]};
            tick_d   = '0;
            on_d     = |cmd_data[22:0];
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            dur_d  = dur_q - 9'd1;
            if (dur_q == 9'd1) begin
              // End of note: period held so the envelope release is audible.
              off_d = |period_q;
              if (en && !cmd_empty) begin
                rd_d    = 1'b1;
                state_d = S_READ;
              end else begin
                und_d   = en;
                state_d = S_IDLE;
              end
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Any cycle with en low releases a STOP halt.
    if (!en) halted_d = 1'b0;
  end

`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Saturating underrun counter, cleared by flush
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                         ucnt_q <= '0;
    else if (flush)                     ucnt_q <= '0;
    else if (und_d && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign cmd_rd_en = rd_q;
  assign period    = period_q;
  assign note_on   = on_q;
  assign note_off  = off_q;
  assign underrun  = und_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer (TICK_DIV=4): FIFO model, note scoreboard checked
// on note_on/note_off, plus directed checks of reset, back-to-back, rest,
// STOP/halt and flush behaviour.
module tb_note_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_empty = 1'b1;
  logic        cmd_rd_en, note_on, note_off, busy, underrun;
  logic [22:0] period;
`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  note_sequencer #(.TICK_DIV(TD), .TICK_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .flush(flush),
    .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
    .period(period), .note_on(note_on), .note_off(note_off),
    .busy(busy), .underrun(underrun)
`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] per;
    int          dur;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fifo[$];
  exp_t        mon_e;
  int n_chk = 0, n_err = 0;
  int cyc = 0, rd_cyc = -100, on_cyc = 0, cur_dur = 0, n_rd = 0;
  bit skip_dur = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Queue a word into the FIFO; sounding notes also go to the scoreboard.
  task automatic push(input logic [31:0] w);
    exp_t e;
    fifo.push_back(w);
    cmd_empty = 1'b0;
    if (!w[31] && w[22:0] != 23'd0) begin
      e.per = w[22:0];
      e.dur = (w[30:23] == 8'd0) ? 256 : int'(w[30:23]);
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for: 0 note_on, 1 note_off, 2 cmd_rd_en
  task automatic wait_for(input int which, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      case (which)
        0: if (note_on)   return;
        1: if (note_off)  return;
        2: if (cmd_rd_en) return;
        default: ;
      endcase
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  // FIFO model and scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_b) begin
      cyc++;
      if (cmd_rd_en) begin
        rd_cyc = cyc;
        n_rd++;
        if (fifo.size() > 0) cmd_data = fifo.pop_front();
        cmd_empty = (fifo.size() == 0);
      end
      if (note_on || note_off) chk("on_off_excl", 32'(note_on & note_off), 0);
      if (note_on) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("on_period", 32'(period), 32'(mon_e.per));
          chk("on_latency", cyc - rd_cyc, 2);
          cur_dur = mon_e.dur;
        end
        on_cyc = cyc;
      end
      if (note_off && !skip_dur) chk("off_dur", cyc - on_cyc, cur_dur * TD);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, n;
    logic ev;
    // 1: reset held with a word pending and en high
    en = 1'b1;
    push(32'h0100_1000);
    repeat (4) begin
      @(negedge clk);
      chk("rst_outs", 32'({cmd_rd_en, note_on, note_off, busy, underrun, period}), 0);
    end
    rst_b = 1'b1;

    // 2: single note, dur 2, ends in underrun
    wait_for(2, 10, "t2_rd");
    @(negedge clk);
    chk("t2_rd_1cyc", 32'(cmd_rd_en), 0);
    wait_for(0, 10, "t2_on");
    chk("t2_period", 32'(period), 32'h1000);
    wait_for(1, 20, "t2_off");
    chk("t2_underrun", 32'(underrun), 1);
    chk("t2_hold", 32'(period), 32'h1000);
    chk("t2_idle", 32'(busy), 0);

    // 3: back-to-back notes
    push(32'h0080_0100);
    push(32'h0080_0200);
    wait_for(1, 30, "t3_off1");
    chk("t3_b2b_rd", 32'(cmd_rd_en), 1);
    wait_for(0, 5, "t3_on2");
    chk("t3_period2", 32'(period), 32'h200);
    wait_for(1, 10, "t3_off2");
    chk("t3_underrun", 32'(underrun), 1);

    // 5: STOP halts reads until en drops
    push(32'h8000_0000);
    push(32'h0080_0300);
    r0 = n_rd;
    repeat (12) @(negedge clk);
    chk("t5_stop_pops", n_rd - r0, 1);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_period_kept", 32'(period), 32'h200);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_for(0, 10, "t5_on");
    chk("t5_period", 32'(period), 32'h300);
    wait_for(1, 10, "t5_off");

    // 4: rest, no envelope events
    push(32'h0080_0000);
    wait_for(2, 10, "t4_rd");
    n = 0;
    ev = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      ev = ev | note_on | note_off;
      @(negedge clk);
    end
    chk("t4_busy_cycles", n, 6);
    chk("t4_no_events", 32'(ev), 0);
    chk("t4_period", 32'(period), 0);

    // 6: long note aborted by flush, pending word not read during flush
    push(32'h0000_0040);
    wait_for(0, 10, "t6_on");
    repeat (100) @(negedge clk);
`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
    chk("ucnt", 32'(underrun_cnt), 4);
`endif
    push(32'h0080_0500);
    skip_dur = 1'b1;
    flush = 1'b1;
    r0 = n_rd;
    @(negedge clk);
    chk("t6_flush_off", 32'(note_off), 1);
    chk("t6_flush_period", 32'(period), 0);
    chk("t6_flush_idle", 32'(busy), 0);
`ifdef NOTE_SEQ_UNDERRUN_CNT_EN
    chk("ucnt_flush", 32'(underrun_cnt), 0);
`endif
    repeat (3) @(negedge clk);
    chk("t6_no_pop", n_rd - r0, 0);
    flush = 1'b0;
    skip_dur = 1'b0;
    wait_for(0, 10, "t6_on2");
    chk("t6_period2", 32'(period), 32'h500);
    wait_for(1, 10, "t6_off2");

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
